read_scheduler: RTL and testbench

READ_SCHEDULER -- requirements
Module: read_scheduler

---
 rtl/read_scheduler.sv | 135 +++++++++++++
 tb/tb_read_scheduler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/read_scheduler.sv
// Round-robin arbiter that hands one Avalon read master to NUM_REQ requesters.
// Misaligned or empty requests are rejected with a req_error pulse instead of being run.
module read_scheduler #(
    parameter int NUM_REQ              = 4,
    parameter int AVALON_ADDRESS_WIDTH = 32,
    parameter int AVALON_DATA_WIDTH    = 32,
    parameter int ID_WIDTH             = 2
) (
    input  logic                                 M_AVALON_CLK,
    input  logic                                 M_AVALON_RST,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ*AVALON_ADDRESS_WIDTH-1:0] req_base,
    input  logic [NUM_REQ*AVALON_ADDRESS_WIDTH-1:0] req_length,
    input  logic [NUM_REQ-1:0]                   req_fixed,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic [NUM_REQ-1:0]                   req_done,
    output logic [NUM_REQ-1:0]                   req_error,
    output logic [ID_WIDTH-1:0]                  grant_id,
    output logic                                 busy,
    output logic                                 control_go,
    output logic [AVALON_ADDRESS_WIDTH-1:0]      control_read_base,
    output logic [AVALON_ADDRESS_WIDTH-1:0]      control_read_length,
    output logic                                 control_fixed_location,
    input  logic                                 control_done
);
    localparam int AW = AVALON_ADDRESS_WIDTH;
    localparam logic [AW-1:0]      WB_MASK = AW'(AVALON_DATA_WIDTH / 8 - 1);
    localparam logic [NUM_REQ-1:0] LSB_ONE = NUM_REQ'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GO,
        S_SETTLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t                state_q;
    logic [ID_WIDTH-1:0]   last_grant_q;
    logic [ID_WIDTH-1:0]   grant_id_q;
    logic [AW-1:0]         base_q;
    logic [AW-1:0]         len_q;
    logic                  fixed_q;
    logic                  go_q;
    logic [NUM_REQ-1:0]    done_q;
    logic [NUM_REQ-1:0]    error_q;

    logic [AW-1:0]         base_arr [NUM_REQ];
    logic [AW-1:0]         len_arr  [NUM_REQ];
    logic [ID_WIDTH-1:0]   winner;
    logic [ID_WIDTH-1:0]   cand;
    logic                  any_valid;
    logic                  reject;
    logic [AW-1:0]         win_base;
    logic [AW-1:0]         win_len;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            base_arr[i] = req_base[i*AW +: AW];
            len_arr[i]  = req_length[i*AW +: AW];
        end
    end

    // Scan from farthest to nearest so the requester right after last_grant wins.
    always_comb begin
        any_valid = |req_valid;
        winner    = last_grant_q;
        cand      = '0;
        for (int unsigned k = NUM_REQ; k >= 1; k--) begin
            cand = last_grant_q + ID_WIDTH'(k);
            if (req_valid[cand]) winner = cand;
        end
    end

    assign win_base = base_arr[winner];
    assign win_len  = len_arr[winner];
    assign reject   = (win_len == '0) || ((win_len & WB_MASK) != '0) ||
                      ((win_base & WB_MASK) != '0);

    always_ff @(posedge M_AVALON_CLK) begin
        if (M_AVALON_RST) begin
            state_q      <= S_IDLE;
            last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
            grant_id_q   <= '0;
            base_q       <= '0;
            len_q        <= '0;
            fixed_q      <= 1'b0;
            go_q         <= 1'b0;
            done_q       <= '0;
            error_q      <= '0;
        end else begin
            go_q    <= 1'b0;
            done_q  <= '0;
            error_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (any_valid) begin
                        base_q       <= win_base;
                        len_q        <= win_len;
                        fixed_q      <= req_fixed[winner];
                        grant_id_q   <= winner;
                        last_grant_q <= winner;
                        if (reject) begin
                            error_q <= LSB_ONE << winner;
                        end else begin
                            state_q <= S_GO;
                            go_q    <= 1'b1;
                        end
                    end
                end
                S_GO:     state_q <= S_SETTLE;
                S_SETTLE: state_q <= S_BUSY;
                S_BUSY: begin
                    if (control_done) begin
                        state_q <= S_DONE;
                        done_q  <= LSB_ONE << grant_id_q;
                    end
                end
                S_DONE:   state_q <= S_IDLE;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready              = (state_q == S_IDLE && any_valid && !M_AVALON_RST) ?
                                    (LSB_ONE << winner) : '0;
    assign req_done               = done_q;
    assign req_error              = error_q;
    assign grant_id               = grant_id_q;
    assign busy                   = (state_q != S_IDLE);
    assign control_go             = go_q;
    assign control_read_base      = base_q;
    assign control_read_length    = len_q;
    assign control_fixed_location = fixed_q;
endmodule

// File: tb/tb_read_scheduler.sv
// Directed bench for read_scheduler: single transfer, rejects, fixed flag,
// reset during BUSY and a full round-robin rotation.
module tb_read_scheduler;
    localparam int N  = 4;
    localparam int AW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_base;
    logic [N*AW-1:0] req_length;
    logic [N-1:0]    req_fixed;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_done;
    logic [N-1:0]    req_error;
    logic [1:0]      grant_id;
    logic            busy;
    logic            control_go;
    logic [AW-1:0]   control_read_base;
    logic [AW-1:0]   control_read_length;
    logic            control_fixed_location;
    logic            control_done;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    read_scheduler #(
        .NUM_REQ(N),
        .AVALON_ADDRESS_WIDTH(AW),
        .AVALON_DATA_WIDTH(32),
        .ID_WIDTH(2)
    ) dut (
        .M_AVALON_CLK(clk),
        .M_AVALON_RST(rst),
        .req_valid(req_valid),
        .req_base(req_base),
        .req_length(req_length),
        .req_fixed(req_fixed),
        .req_ready(req_ready),
        .req_done(req_done),
        .req_error(req_error),
        .grant_id(grant_id),
        .busy(busy),
        .control_go(control_go),
        .control_read_base(control_read_base),
        .control_read_length(control_read_length),
        .control_fixed_location(control_fixed_location),
        .control_done(control_done)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [31:0] b,
                           input logic [31:0] l, input logic f);
        req_valid[i]             = v;
        req_base[i*AW +: AW]     = b;
        req_length[i*AW +: AW]   = l;
        req_fixed[i]             = f;
    endtask

    task automatic check_reset_vals();
        check_val("rst_busy",  64'(busy), 64'(0));
        check_val("rst_go",    64'(control_go), 64'(0));
        check_val("rst_grant", 64'(grant_id), 64'(0));
        check_val("rst_base",  64'(control_read_base), 64'(0));
        check_val("rst_len",   64'(control_read_length), 64'(0));
        check_val("rst_fixed", 64'(control_fixed_location), 64'(0));
        check_val("rst_ready", 64'(req_ready), 64'(0));
        check_val("rst_done",  64'(req_done), 64'(0));
        check_val("rst_error", 64'(req_error), 64'(0));
    endtask

    // Entered at the start of the IDLE cycle in which requester g should win.
    task automatic do_grant(input int g, input logic [31:0] b, input logic [31:0] l,
                            input logic f, input bit early, input bit clear);
        logic [3:0] oh;
        oh = 4'b0001 << g;
        @(negedge clk);
        check_val("ready", 64'(req_ready), 64'(oh));
        next_cycle();
        if (clear) req_valid[g] = 1'b0;
        control_done = early;
        @(negedge clk);
        check_val("go",      64'(control_go), 64'(1));
        check_val("grant",   64'(grant_id), 64'(g));
        check_val("base",    64'(control_read_base), 64'(b));
        check_val("len",     64'(control_read_length), 64'(l));
        check_val("fixed",   64'(control_fixed_location), 64'(f));
        check_val("rdy_go",  64'(req_ready), 64'(0));
        check_val("busy_go", 64'(busy), 64'(1));
        check_val("done_go", 64'(req_done), 64'(0));
        next_cycle();
        @(negedge clk);
        check_val("go_settle",   64'(control_go), 64'(0));
        check_val("done_settle", 64'(req_done), 64'(0));
        next_cycle();
        @(negedge clk);
        check_val("done_busy", 64'(req_done), 64'(0));
        check_val("busy_busy", 64'(busy), 64'(1));
        if (!early) begin
            next_cycle();
            control_done = 1'b1;
            @(negedge clk);
            check_val("done_wait", 64'(req_done), 64'(0));
        end
        next_cycle();
        @(negedge clk);
        check_val("done",       64'(req_done), 64'(oh));
        check_val("fixed_done", 64'(control_fixed_location), 64'(f));
        check_val("base_done",  64'(control_read_base), 64'(b));
        control_done = early;
    endtask

    initial begin
        int order [4] = '{1, 2, 3, 0};
        rst          = 1'b1;
        req_valid    = '0;
        req_base     = '0;
        req_length   = '0;
        req_fixed    = '0;
        control_done = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals();

        // single request on requester 1
        next_cycle();
        set_req(1, 1'b1, 32'h1000, 32'h40, 1'b0);
        do_grant(1, 32'h1000, 32'h40, 1'b0, 1'b0, 1'b1);

        // rejects: zero length, misaligned base, length not a word multiple
        next_cycle();
        set_req(2, 1'b1, 32'h100, 32'h0, 1'b0);
        @(negedge clk);
        check_val("rej0_ready", 64'(req_ready), 64'(4'b0100));
        next_cycle();
        req_valid[2] = 1'b0;
        @(negedge clk);
        check_val("rej0_error", 64'(req_error), 64'(4'b0100));
        check_val("rej0_go",    64'(control_go), 64'(0));
        check_val("rej0_busy",  64'(busy), 64'(0));
        next_cycle();
        set_req(3, 1'b1, 32'h1002, 32'h40, 1'b0);
        @(negedge clk);
        check_val("rej1_ready",  64'(req_ready), 64'(4'b1000));
        check_val("rej1_noerr",  64'(req_error), 64'(0));
        next_cycle();
        req_valid[3] = 1'b0;
        @(negedge clk);
        check_val("rej1_error", 64'(req_error), 64'(4'b1000));
        check_val("rej1_go",    64'(control_go), 64'(0));
        next_cycle();
        set_req(0, 1'b1, 32'h0, 32'h42, 1'b0);
        @(negedge clk);
        check_val("rej2_ready", 64'(req_ready), 64'(4'b0001));
        next_cycle();
        req_valid[0] = 1'b0;
        @(negedge clk);
        check_val("rej2_error", 64'(req_error), 64'(4'b0001));
        check_val("rej2_go",    64'(control_go), 64'(0));
        check_val("rej2_done",  64'(req_done), 64'(0));

        // fixed-location grant, then a non-fixed one clears the flag
        next_cycle();
        set_req(2, 1'b1, 32'h2000, 32'h80, 1'b1);
        do_grant(2, 32'h2000, 32'h80, 1'b1, 1'b1, 1'b1);
        next_cycle();
        set_req(0, 1'b1, 32'h2400, 32'h8, 1'b0);
        do_grant(0, 32'h2400, 32'h8, 1'b0, 1'b0, 1'b1);

        // reset while BUSY
        next_cycle();
        set_req(1, 1'b1, 32'h3000, 32'h10, 1'b0);
        @(negedge clk);
        check_val("pre_rst_ready", 64'(req_ready), 64'(4'b0010));
        next_cycle();
        req_valid[1] = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_val("pre_rst_busy", 64'(busy), 64'(1));
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals();
        next_cycle();
        @(negedge clk);
        check_val("post_rst_done", 64'(req_done), 64'(0));
        next_cycle();
        set_req(0, 1'b1, 32'h400, 32'h8, 1'b0);
        set_req(2, 1'b1, 32'h500, 32'h8, 1'b0);
        do_grant(0, 32'h400, 32'h8, 1'b0, 1'b0, 1'b1);
        next_cycle();
        req_valid = '0;

        // full rotation with every requester held valid and control_done held high
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < N; i++)
            set_req(i, 1'b1, 32'(32'h100 * (i + 1)), 32'(32'h20 * (i + 1)), 1'b0);
        control_done = 1'b1;
        do_grant(0, 32'h100, 32'h20, 1'b0, 1'b1, 1'b0);
        for (int j = 0; j < 4; j++) begin
            next_cycle();
            do_grant(order[j], 32'(32'h100 * (order[j] + 1)), 32'(32'h20 * (order[j] + 1)),
                     1'b0, 1'b1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
